// File: rtl/rom_fetch_if.sv
// ----------------------------------------------------------------------------
// rom_fetch_if
//   Fetch-to-decode handshake bundle. The fetch stage presents the head of its
//   prefetch FIFO; the consumer accepts it with fetch_ready_i.
//   Signals:
//     fetch_valid_o  head entry valid                 (master -> slave)
//     fetch_ready_i  consumer accepts the head entry  (slave  -> master)
//     fetch_data_o   head instruction word            (master -> slave)
//     fetch_addr_o   word address of the head entry   (master -> slave)
//     fetch_error_o  head entry carries a ROM error   (master -> slave)
// ----------------------------------------------------------------------------
interface rom_fetch_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  fetch_valid_o;
    logic                  fetch_ready_i;
    logic [DATA_WIDTH-1:0] fetch_data_o;
    logic [ADDR_WIDTH-1:0] fetch_addr_o;
    logic                  fetch_error_o;

    modport master (
        output fetch_valid_o,
        output fetch_data_o,
        output fetch_addr_o,
        output fetch_error_o,
        input  fetch_ready_i
    );

    modport slave (
        input  fetch_valid_o,
        input  fetch_data_o,
        input  fetch_addr_o,
        input  fetch_error_o,
        output fetch_ready_i
    );
endinterface

// File: rtl/rom_fetch.sv
// ----------------------------------------------------------------------------
// rom_fetch
//   Instruction fetch stage sitting directly upstream of a combinational ROM.
//   Holds the fetch PC, drives the ROM address, captures {data, addr, error}
//   into a small prefetch FIFO and presents the head entry to decode.
//   A redirect reloads the PC and flushes the FIFO; a ROM error halts issue
//   until the next redirect while the FIFO keeps draining.
//   Ports:
//     clk_i            clock, rising edge
//     rst_i            asynchronous, active-high reset
//     redirect_i       load PC from redirect_addr_i and flush the FIFO
//     redirect_addr_i  new fetch address
//     rom_addr_o       ROM address (the PC register)
//     rom_data_i       ROM word at rom_addr_o, same cycle
//     rom_error_i      ROM error flag for rom_addr_o
//     fetch            handshake bundle to decode (master side)
//     halted_o         fetch is halted after a ROM error
//     count_o          FIFO occupancy, 0..FIFO_DEPTH
// ----------------------------------------------------------------------------
module rom_fetch #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          redirect_i,
    input  logic [ADDR_WIDTH-1:0]         redirect_addr_i,
    output logic [ADDR_WIDTH-1:0]         rom_addr_o,
    input  logic [DATA_WIDTH-1:0]         rom_data_i,
    input  logic                          rom_error_i,
    rom_fetch_if.master                   fetch,
    output logic                          halted_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // Entry storage: data only, never reset; visibility is governed by r_count.
    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
    logic                  r_mem_err  [FIFO_DEPTH];

    logic w_valid;
    logic w_pop;
    logic w_issue;

    // Valid is gated by redirect so a flush cycle never also pops an entry.
    assign w_valid = (r_count != '0) && !redirect_i;
    assign w_pop   = w_valid && fetch.fetch_ready_i;
    // A full FIFO may still issue when the head leaves in the same cycle.
    assign w_issue = (r_state == ST_RUN) && !redirect_i &&
                     ((r_count < CNT_W'(FIFO_DEPTH)) || w_pop);

    assign rom_addr_o          = r_pc;
    assign halted_o            = (r_state == ST_HALT);
    assign count_o             = r_count;
    assign fetch.fetch_valid_o = w_valid;
    assign fetch.fetch_data_o  = w_valid ? r_mem_data[r_rd_ptr] : '0;
    assign fetch.fetch_addr_o  = w_valid ? r_mem_addr[r_rd_ptr] : '0;
    assign fetch.fetch_error_o = w_valid ? r_mem_err[r_rd_ptr]  : 1'b0;

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_i) begin
            w_state_nxt = ST_RUN;
        end else if (w_issue && rom_error_i) begin
            w_state_nxt = ST_HALT;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc     <= RESET_ADDR;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_i) begin
            r_pc     <= redirect_addr_i;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // PC holds on an erroring word so the faulting address is retained.
            if (w_issue && !rom_error_i) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_issue) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_issue) begin
            r_mem_data[r_wr_ptr] <= rom_data_i;
            r_mem_addr[r_wr_ptr] <= r_pc;
            r_mem_err[r_wr_ptr]  <= rom_error_i;
        end
    end

endmodule
